level0_mem_arbiter: RTL and testbench

Sequencer and arbiter in front of the single-port level-0 register memory (DEPTH x DATA_WIDTH, active-low chip enable, active-high write enable, 1-cycle registered read).
- After reset it zero-initialises every entry, because the memory array has no reset.
- It then shares the port among NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- It returns one response per accepted request.

---
 rtl/level0_mem_pkg.sv | 12 +
 rtl/level0_mem_arbiter_rr.sv | 32 +++
 rtl/level0_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_level0_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level0_mem_pkg.sv
// Shared types and default geometry for the level-0 register memory and its arbiter.
package level0_mem_pkg;

    localparam int L0_DATA_WIDTH = 48;
    localparam int L0_ADDR_WIDTH = 4;
    localparam int L0_DEPTH      = 10;

    typedef enum logic {ST_INIT, ST_RUN} l0_state_e;

    typedef logic [L0_DATA_WIDTH-1:0] l0_word_t;

endpackage

// File: rtl/level0_mem_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/level0_mem_arbiter.sv
// Zero-fills the level-0 register memory after reset, then shares its single port
// among NUM_REQ requesters round-robin with a fixed one-cycle response.
module level0_mem_arbiter
    import level0_mem_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = L0_DATA_WIDTH,
    parameter int ADDR_WIDTH = L0_ADDR_WIDTH,
    parameter int DEPTH      = L0_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          init_done,
    output logic                          mem_cen_n,
    output logic                          mem_wen,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic [DATA_WIDTH-1:0]         mem_data_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    l0_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   rsp_pending_q, rsp_pending_d;
    logic [PTR_W-1:0]       rsp_id_q, rsp_id_d;
    logic                   rsp_is_read_q, rsp_is_read_d;
    logic                   rsp_is_err_q, rsp_is_err_d;

    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   any_grant;
    logic                   gnt_we;
    logic [ADDR_WIDTH-1:0]  gnt_addr;
    logic [DATA_WIDTH-1:0]  gnt_wdata;
    logic                   gnt_in_range;

    // Nobody is granted while initialising or while reset is being applied.
    assign arb_req = (state_q == ST_RUN && !rst) ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        gnt_we       = req_we[grant_idx];
        gnt_addr     = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_wdata    = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        gnt_in_range = int'(gnt_addr) < DEPTH;
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_pending_d = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_is_read_d = 1'b0;
        rsp_is_err_d  = 1'b0;
        mem_cen_n     = 1'b1;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_data_in   = '0;
        case (state_q)
            ST_INIT: begin
                mem_cen_n = 1'b0;
                mem_wen   = 1'b1;
                mem_addr  = init_cnt_q;
                if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (any_grant) begin
                    rr_ptr_d      = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    rsp_pending_d = 1'b1;
                    rsp_id_d      = grant_idx;
                    rsp_is_read_d = !gnt_we;
                    rsp_is_err_d  = !gnt_in_range;
                    // Out-of-range accesses are answered with an error but never touch the array.
                    if (gnt_in_range) begin
                        mem_cen_n   = 1'b0;
                        mem_wen     = gnt_we;
                        mem_addr    = gnt_addr;
                        mem_data_in = gnt_wdata;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            rr_ptr_q      <= '0;
            rsp_pending_q <= 1'b0;
            rsp_id_q      <= '0;
            rsp_is_read_q <= 1'b0;
            rsp_is_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_id_q      <= rsp_id_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_is_err_q  <= rsp_is_err_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_pending_q) begin
            rsp_valid[rsp_id_q] = 1'b1;
        end
        rsp_err   = rsp_pending_q && rsp_is_err_q;
        rsp_rdata = (rsp_pending_q && rsp_is_read_q && !rsp_is_err_q) ? mem_data_out : '0;
        init_done = (state_q == ST_RUN);
        req_ready = grant;
    end

endmodule

// File: tb/tb_level0_mem_arbiter.sv
// Self-checking bench for level0_mem_arbiter: directed table, hand sequences for init/reset,
// and constrained-random traffic against a transaction-level reference model.
module tb_level0_mem_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 48;
    localparam int AW  = 4;
    localparam int DEP = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic              init_done;
    logic              mem_cen_n;
    logic              mem_wen;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_in;
    logic [DW-1:0]     mem_data_out;

    always #5 clk = ~clk;

    level0_mem_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .init_done    (init_done),
        .mem_cen_n    (mem_cen_n),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Behavioural single-port memory with registered read and no reset (starts as garbage).
    logic [DW-1:0] sram [16];
    bit            sram_filled = 1'b0;

    always @(posedge clk) begin
        if (!sram_filled) begin
            for (int i = 0; i < 16; i++) sram[i] = DW'({$urandom, $urandom});
            sram_filled = 1'b1;
        end
        if (mem_cen_n === 1'b0) begin
            if (mem_wen) sram[mem_addr] = mem_data_in;
            else         mem_data_out <= sram[mem_addr];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: expected memory contents plus an abstract view of arbitration.
    bit            m_running;
    int            m_idx;
    int            m_ptr;
    int            m_grant;
    bit            m_pend;
    int            m_pend_id;
    bit            m_pend_err;
    logic [DW-1:0] m_pend_rdata;
    logic [DW-1:0] ref_mem [DEP];
    logic [NR-1:0] e_ready;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [NR-1:0] e_rsp;
        logic          e_cen_n, e_wen, e_err;
        logic [AW-1:0] e_addr, g_addr;
        logic [DW-1:0] e_din, e_rdata;
        m_grant = -1;
        if (m_running && !rst) begin
            for (int k = 0; k < NR; k++) begin
                if (m_grant < 0 && req_valid[(m_ptr + k) % NR]) m_grant = (m_ptr + k) % NR;
            end
        end
        e_ready = (m_grant >= 0) ? NR'(1 << m_grant) : '0;
        g_addr  = (m_grant >= 0) ? req_addr[m_grant*AW +: AW] : '0;
        if (!m_running) begin
            e_cen_n = 1'b0; e_wen = 1'b1; e_addr = AW'(m_idx); e_din = '0;
        end else if (m_grant >= 0 && int'(g_addr) < DEP) begin
            e_cen_n = 1'b0; e_wen = req_we[m_grant]; e_addr = g_addr;
            e_din   = req_wdata[m_grant*DW +: DW];
        end else begin
            e_cen_n = 1'b1; e_wen = 1'b0; e_addr = '0; e_din = '0;
        end
        e_rsp   = m_pend ? NR'(1 << m_pend_id) : '0;
        e_err   = m_pend && m_pend_err;
        e_rdata = m_pend ? m_pend_rdata : '0;
        if (!rst) begin
            cmp("req_ready",   64'(req_ready),   64'(e_ready));
            cmp("rsp_valid",   64'(rsp_valid),   64'(e_rsp));
            cmp("rsp_err",     64'(rsp_err),     64'(e_err));
            cmp("rsp_rdata",   64'(rsp_rdata),   64'(e_rdata));
            cmp("init_done",   64'(init_done),   64'(m_running));
            cmp("mem_cen_n",   64'(mem_cen_n),   64'(e_cen_n));
            cmp("mem_wen",     64'(mem_wen),     64'(e_wen));
            cmp("mem_addr",    64'(mem_addr),    64'(e_addr));
            cmp("mem_data_in", 64'(mem_data_in), 64'(e_din));
        end
        // Advance the model to what should hold after the coming clock edge.
        if (rst) begin
            m_running = 1'b0; m_idx = 0; m_ptr = 0; m_pend = 1'b0;
        end else if (!m_running) begin
            ref_mem[m_idx] = '0;
            m_pend = 1'b0;
            m_idx++;
            if (m_idx == DEP) begin
                m_running = 1'b1;
                m_idx     = 0;
            end
        end else begin
            m_pend = (m_grant >= 0);
            if (m_grant >= 0) begin
                m_pend_id = m_grant;
                if (int'(g_addr) >= DEP) begin
                    m_pend_err = 1'b1; m_pend_rdata = '0;
                end else begin
                    m_pend_err = 1'b0;
                    if (req_we[m_grant]) begin
                        ref_mem[g_addr] = req_wdata[m_grant*DW +: DW];
                        m_pend_rdata    = '0;
                    end else begin
                        m_pend_rdata = ref_mem[g_addr];
                    end
                end
                m_ptr = (m_grant + 1) % NR;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] we,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic [NR-1:0] v;
        logic [NR-1:0] we;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [NR-1:0] x_ready;
        logic [NR-1:0] x_rsp;
        logic          x_err;
        logic [DW-1:0] x_rdata;
        logic          x_cen_n;
    } vec_t;

    localparam logic [DW-1:0] DA = 48'h1234_5678_9ABC;
    localparam logic [DW-1:0] DB = 48'hFEDC_BA98_7654;

    vec_t tbl [12];

    logic [NR-1:0] p_v, p_we;
    logic [AW-1:0] p_a [NR];
    logic [DW-1:0] p_d [NR];

    initial begin
        tbl[0]  = '{2'b01, 2'b01, 4'd3, 4'd0, DA,  48'd0, 2'b01, 2'b00, 1'b0, 48'd0, 1'b0};
        tbl[1]  = '{2'b01, 2'b00, 4'd3, 4'd0, 48'd0, 48'd0, 2'b01, 2'b01, 1'b0, 48'd0, 1'b0};
        tbl[2]  = '{2'b10, 2'b10, 4'd0, 4'd1, 48'd0, DB,  2'b10, 2'b01, 1'b0, DA,    1'b0};
        tbl[3]  = '{2'b11, 2'b00, 4'd1, 4'd2, 48'd0, 48'd0, 2'b01, 2'b10, 1'b0, 48'd0, 1'b0};
        tbl[4]  = '{2'b11, 2'b00, 4'd1, 4'd2, 48'd0, 48'd0, 2'b10, 2'b01, 1'b0, DB,    1'b0};
        tbl[5]  = '{2'b11, 2'b00, 4'd1, 4'd2, 48'd0, 48'd0, 2'b01, 2'b10, 1'b0, 48'd0, 1'b0};
        tbl[6]  = '{2'b11, 2'b00, 4'd1, 4'd2, 48'd0, 48'd0, 2'b10, 2'b01, 1'b0, DB,    1'b0};
        tbl[7]  = '{2'b11, 2'b00, 4'd1, 4'd2, 48'd0, 48'd0, 2'b01, 2'b10, 1'b0, 48'd0, 1'b0};
        tbl[8]  = '{2'b11, 2'b00, 4'd1, 4'd2, 48'd0, 48'd0, 2'b10, 2'b01, 1'b0, DB,    1'b0};
        tbl[9]  = '{2'b10, 2'b00, 4'd0, 4'd12, 48'd0, 48'd0, 2'b10, 2'b10, 1'b0, 48'd0, 1'b1};
        tbl[10] = '{2'b00, 2'b00, 4'd0, 4'd0, 48'd0, 48'd0, 2'b00, 2'b10, 1'b1, 48'd0, 1'b1};
        tbl[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 48'd0, 48'd0, 2'b00, 2'b00, 1'b0, 48'd0, 1'b1};

        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        m_running = 1'b0; m_idx = 0; m_ptr = 0; m_pend = 1'b0; m_grant = -1;
        m_pend_id = 0; m_pend_err = 1'b0; m_pend_rdata = '0;

        $display("[TB] reset and initialisation, requester 0 waiting with a read of addr 5");
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
        applyStimulus(1'b1, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
        for (int i = 0; i < DEP; i++) begin
            applyStimulus(1'b0, 2'b01, 2'b00, 4'd5, 4'd0, '0, '0);
            cmp("init_addr",  64'(mem_addr),  64'(i));
            cmp("init_cen_n", 64'(mem_cen_n), 64'd0);
            cmp("init_wen",   64'(mem_wen),   64'd1);
            cmp("init_ready", 64'(req_ready), 64'd0);
            cmp("init_done0", 64'(init_done), 64'd0);
        end
        applyStimulus(1'b0, 2'b01, 2'b00, 4'd5, 4'd0, '0, '0);
        cmp("init_done1",  64'(init_done), 64'd1);
        cmp("first_ready", 64'(req_ready), 64'b01);
        for (int i = 0; i < DEP; i++) begin
            applyStimulus(1'b0, 2'b01, 2'b00, AW'(i), 4'd0, '0, '0);
            cmp("zero_rsp",   64'(rsp_valid), 64'b01);
            cmp("zero_rdata", 64'(rsp_rdata), 64'd0);
            cmp("zero_err",   64'(rsp_err),   64'd0);
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
        cmp("zero_rdata9", 64'(rsp_rdata), 64'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            cmp("tbl_ready", 64'(req_ready), 64'(tbl[i].x_ready));
            cmp("tbl_rsp",   64'(rsp_valid), 64'(tbl[i].x_rsp));
            cmp("tbl_err",   64'(rsp_err),   64'(tbl[i].x_err));
            cmp("tbl_rdata", 64'(rsp_rdata), 64'(tbl[i].x_rdata));
            cmp("tbl_cen_n", 64'(mem_cen_n), 64'(tbl[i].x_cen_n));
        end

        $display("[TB] reset right after an accepted read");
        applyStimulus(1'b0, 2'b01, 2'b00, 4'd3, 4'd0, '0, '0);
        cmp("pre_rst_ready", 64'(req_ready), 64'b01);
        applyStimulus(1'b1, 2'b01, 2'b00, 4'd3, 4'd0, '0, '0);
        for (int i = 0; i < DEP; i++) begin
            applyStimulus(1'b0, 2'b01, 2'b00, 4'd3, 4'd0, '0, '0);
            cmp("rst_no_rsp", 64'(rsp_valid), 64'd0);
            cmp("rst_ready",  64'(req_ready), 64'd0);
            cmp("rst_addr",   64'(mem_addr),  64'(i));
        end
        applyStimulus(1'b0, 2'b01, 2'b00, 4'd3, 4'd0, '0, '0);
        cmp("rerun_ready", 64'(req_ready), 64'b01);
        applyStimulus(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);
        cmp("rerun_rsp",   64'(rsp_valid), 64'b01);
        cmp("rerun_rdata", 64'(rsp_rdata), 64'd0);

        $display("[TB] random traffic");
        p_v = '0; p_we = '0;
        for (int k = 0; k < NR; k++) begin p_a[k] = '0; p_d[k] = '0; end
        for (int c = 0; c < 600; c++) begin
            logic r;
            for (int k = 0; k < NR; k++) begin
                if (!p_v[k] && ($urandom % 3) != 0) begin
                    p_v[k]  = 1'b1;
                    p_we[k] = 1'($urandom);
                    p_a[k]  = AW'($urandom_range(0, 12));
                    p_d[k]  = DW'({$urandom, $urandom});
                end
            end
            r = (($urandom % 150) == 0);
            applyStimulus(r, p_v, p_we, p_a[0], p_a[1], p_d[0], p_d[1]);
            p_v = p_v & ~e_ready;
            if (($urandom % 4) == 0) p_v = p_v & e_ready;
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
